// File: rtl/hs_unit_ce_gen.sv
// rtl/hs_unit_ce_gen.sv - programmable clock-enable strobe generator
//
// Purpose:
//   Emits a single-cycle ce strobe every div_cur+1 clocks, either
//   free-running (burst_len = 0) or for a finite burst of burst_len
//   pulses. Divisor updates take effect only at period boundaries,
//   so the strobe spacing never glitches.
//
// Optional feature (macro HS_UNIT_CE_GEN_PULSE_CNT_EN):
//   Adds pulse_total (saturating 32-bit count of ce pulses since reset)
//   and pulse_clr (synchronous clear, wins over a same-cycle increment).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   pulse; begins generation when idle
//   stop         in   pulse; aborts generation (wins over start)
//   burst_len    in   pulses per run, sampled at start; 0 = free-running
//   div_in       in   new divisor; period = div_in+1 cycles
//   div_load     in   pulse; captures div_in as the pending divisor
//   ce           out  strobe, one cycle per period
//   busy         out  high while running
//   done         out  one-cycle pulse after the last pulse of a burst
//   div_cur      out  currently active divisor
//   pulse_total  out  (optional) saturating pulse count
//   pulse_clr    in   (optional) clears pulse_total

module hs_unit_ce_gen #(
    parameter int                CNT_W       = 16,
    parameter int                BURST_W     = 8,
    parameter logic [CNT_W-1:0]  DEFAULT_DIV = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [CNT_W-1:0]   div_in,
    input  logic               div_load,
    output logic               ce,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   div_cur
`ifdef HS_UNIT_CE_GEN_PULSE_CNT_EN
    ,
    output logic [31:0]        pulse_total,
    input  logic               pulse_clr
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_div_cur;
    logic [CNT_W-1:0]     r_div_pend;
    logic                 r_pend_vld;
    logic [BURST_W-1:0]   r_pulse_cnt;
    logic [BURST_W-1:0]   r_len;
    logic                 r_done;

    logic                 w_ce;
    logic                 w_last;
    logic                 w_start_ok;
    logic [CNT_W-1:0]     w_div_eff;
    logic [CNT_W-1:0]     w_reload_div;

    // Divisor that would be active if a boundary happened now: a pending
    // value, if any, replaces the current one.
    assign w_div_eff    = r_pend_vld ? r_div_pend : r_div_cur;

    // A div_load landing exactly on a reload cycle is used for that reload.
    assign w_reload_div = div_load ? div_in : w_div_eff;

    assign w_start_ok   = start && !stop;

    // ce is decoded from registered state; a same-cycle stop suppresses it.
    assign w_ce         = (r_state == S_RUN) && (r_cnt == '0) && !stop;

    // The pulse being emitted now is the final one of a finite burst.
    assign w_last       = (r_len != '0) && (r_pulse_cnt == (r_len - BURST_W'(1)));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ce && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div_cur   <= DEFAULT_DIV;
            r_div_pend  <= '0;
            r_pend_vld  <= 1'b0;
            r_pulse_cnt <= '0;
            r_len       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_ce && w_last;

            case (r_state)
                S_IDLE: begin
                    // Nothing is counting, so a pending divisor can be
                    // applied right away; a new load in this cycle is
                    // captured and applied on the following edge.
                    r_div_cur  <= w_div_eff;
                    r_pend_vld <= 1'b0;
                    if (div_load) begin
                        r_div_pend <= div_in;
                        r_pend_vld <= 1'b1;
                    end
                    if (w_start_ok) begin
                        r_cnt       <= w_div_eff;
                        r_pulse_cnt <= '0;
                        r_len       <= burst_len;
                    end
                end
                S_RUN: begin
                    if (w_ce) begin
                        // Period boundary: reload and switch divisor together
                        r_cnt       <= w_reload_div;
                        r_div_cur   <= w_reload_div;
                        r_pend_vld  <= 1'b0;
                        r_pulse_cnt <= r_pulse_cnt + BURST_W'(1);
                    end else begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                        if (div_load) begin
                            r_div_pend <= div_in;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ce      = w_ce;
    assign busy    = (r_state == S_RUN);
    assign done    = r_done;
    assign div_cur = r_div_cur;

`ifdef HS_UNIT_CE_GEN_PULSE_CNT_EN
    logic [31:0] r_pulse_total;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse_total <= '0;
        end else if (pulse_clr) begin
            r_pulse_total <= '0;
        end else if (w_ce && (r_pulse_total != 32'hFFFF_FFFF)) begin
            r_pulse_total <= r_pulse_total + 32'd1;
        end
    end

    assign pulse_total = r_pulse_total;
`endif

endmodule

// File: tb/tb_hs_unit_ce_gen.sv
// tb/tb_hs_unit_ce_gen.sv - directed self-checking bench for hs_unit_ce_gen

module tb_hs_unit_ce_gen;

    localparam int          CNT_W   = 16;
    localparam int          BURST_W = 8;
    localparam logic [15:0] DEF_DIV = 16'd5;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stop;
    logic [BURST_W-1:0] burst_len;
    logic [CNT_W-1:0]   div_in;
    logic               div_load;
    logic               ce;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   div_cur;
`ifdef HS_UNIT_CE_GEN_PULSE_CNT_EN
    logic [31:0]        pulse_total;
    logic               pulse_clr;
`endif

    int n_tests;
    int n_fail;

    hs_unit_ce_gen #(
        .CNT_W      (CNT_W),
        .BURST_W    (BURST_W),
        .DEFAULT_DIV(DEF_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .div_in     (div_in),
        .div_load   (div_load),
        .ce         (ce),
        .busy       (busy),
        .done       (done),
        .div_cur    (div_cur)
`ifdef HS_UNIT_CE_GEN_PULSE_CNT_EN
        ,
        .pulse_total(pulse_total),
        .pulse_clr  (pulse_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Load a divisor while idle and let it be applied (capture edge + apply edge).
    task automatic load_div_idle(input logic [CNT_W-1:0] d);
        div_in   = d;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
    endtask

    // Drive start for one edge (edge 0); returns just after edge 0.
    task automatic pulse_start(input logic [BURST_W-1:0] len);
        burst_len = len;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        burst_len = '0;
        div_in    = '0;
        div_load  = 1'b0;
`ifdef HS_UNIT_CE_GEN_PULSE_CNT_EN
        pulse_clr = 1'b0;
`endif
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ce !== 1'b0) begin
            n_fail++; $display("FAIL reset_ce: got %b want 0", ce);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", done);
        end
        n_tests++;
        if (div_cur !== DEF_DIV) begin
            n_fail++; $display("FAIL reset_div_cur: got %0d want %0d", div_cur, DEF_DIV);
        end
        step();
    endtask

    task automatic test_burst;
        logic exp_ce, exp_busy, exp_done;
        load_div_idle(16'd3);
        @(negedge clk);
        n_tests++;
        if (div_cur !== 16'd3) begin
            n_fail++; $display("FAIL burst_div_idle_load: got %0d want 3", div_cur);
        end
        pulse_start(8'd4);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_ce   = (c % 4 == 0) && (c <= 16);
            exp_busy = (c <= 16);
            exp_done = (c == 17);
            n_tests++;
            if (ce !== exp_ce) begin
                n_fail++; $display("FAIL burst_ce c%0d: got %b want %b", c, ce, exp_ce);
            end
            n_tests++;
            if (busy !== exp_busy) begin
                n_fail++; $display("FAIL burst_busy c%0d: got %b want %b", c, busy, exp_busy);
            end
            n_tests++;
            if (done !== exp_done) begin
                n_fail++; $display("FAIL burst_done c%0d: got %b want %b", c, done, exp_done);
            end
            step();
        end
    endtask

    task automatic test_free_stop;
        int n_ce;
        n_ce = 0;
        load_div_idle(16'd0);
        pulse_start(8'd0);
        for (int c = 1; c <= 13; c++) begin
            stop = (c == 10);
            @(negedge clk);
            if (ce === 1'b1) n_ce++;
            n_tests++;
            if (ce !== (c <= 9)) begin
                n_fail++; $display("FAIL free_ce c%0d: got %b want %b", c, ce, (c <= 9));
            end
            n_tests++;
            if (busy !== (c <= 10)) begin
                n_fail++; $display("FAIL free_busy c%0d: got %b want %b", c, busy, (c <= 10));
            end
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++; $display("FAIL free_no_done c%0d: got %b want 0", c, done);
            end
            step();
        end
        stop = 1'b0;
        n_tests++;
        if (n_ce != 9) begin
            n_fail++; $display("FAIL free_pulse_count: got %0d want 9", n_ce);
        end
    endtask

    task automatic test_div_change;
        logic             exp_ce;
        logic [CNT_W-1:0] exp_div;
        load_div_idle(16'd4);
        pulse_start(8'd0);
        for (int c = 1; c <= 12; c++) begin
            div_load = (c == 2);
            div_in   = (c == 2) ? 16'd1 : 16'd9;
            @(negedge clk);
            exp_ce  = (c == 5) || (c == 7) || (c == 9) || (c == 11);
            exp_div = (c <= 5) ? 16'd4 : 16'd1;
            n_tests++;
            if (ce !== exp_ce) begin
                n_fail++; $display("FAIL divchg_ce c%0d: got %b want %b", c, ce, exp_ce);
            end
            n_tests++;
            if (div_cur !== exp_div) begin
                n_fail++; $display("FAIL divchg_div_cur c%0d: got %0d want %0d", c, div_cur, exp_div);
            end
            step();
        end
        div_load = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL divchg_stop_busy: got %b want 0", busy);
        end
        step();
    endtask

    task automatic test_start_stop;
        logic exp_ce;
        // div_cur is 1 here
        burst_len = 8'd2;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || ce !== 1'b0) begin
                n_fail++; $display("FAIL startstop_idle c%0d: got busy=%b ce=%b want 0 0", c, busy, ce);
            end
            step();
        end
        pulse_start(8'd2);
        for (int c = 1; c <= 8; c++) begin
            start     = (c == 3);
            burst_len = (c == 3) ? 8'd7 : 8'd2;
            @(negedge clk);
            exp_ce = (c == 2) || (c == 4);
            n_tests++;
            if (ce !== exp_ce) begin
                n_fail++; $display("FAIL b2b_ce c%0d: got %b want %b", c, ce, exp_ce);
            end
            n_tests++;
            if (busy !== (c <= 4)) begin
                n_fail++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy, (c <= 4));
            end
            n_tests++;
            if (done !== (c == 5)) begin
                n_fail++; $display("FAIL b2b_done c%0d: got %b want %b", c, done, (c == 5));
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midrun;
        // div_cur is 1 here: ce in cycle 2, reset during cycle 3
        pulse_start(8'd0);
        for (int c = 1; c <= 6; c++) begin
            reset = (c == 3);
            @(negedge clk);
            if (c == 2) begin
                n_tests++;
                if (ce !== 1'b1) begin
                    n_fail++; $display("FAIL rstmid_running_ce: got %b want 1", ce);
                end
            end
            if (c >= 4) begin
                n_tests++;
                if (ce !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_outputs c%0d: got ce=%b busy=%b done=%b want 0 0 0", c, ce, busy, done);
                end
                n_tests++;
                if (div_cur !== DEF_DIV) begin
                    n_fail++; $display("FAIL rstmid_div_cur c%0d: got %0d want %0d", c, div_cur, DEF_DIV);
                end
            end
            step();
        end
        reset = 1'b0;
    endtask

`ifdef HS_UNIT_CE_GEN_PULSE_CNT_EN
    task automatic test_pulse_cnt;
        pulse_clr = 1'b1;
        step();
        pulse_clr = 1'b0;
        load_div_idle(16'd1);
        pulse_start(8'd5);
        repeat (14) step();
        @(negedge clk);
        n_tests++;
        if (pulse_total !== 32'd5) begin
            n_fail++; $display("FAIL pcnt_burst5: got %0d want 5", pulse_total);
        end
        step();
        // free-run with div 1: ce in cycle 2; clear exactly in that cycle
        pulse_start(8'd0);
        step();
        pulse_clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ce !== 1'b1) begin
            n_fail++; $display("FAIL pcnt_clr_align_ce: got %b want 1", ce);
        end
        step();
        pulse_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pulse_total !== 32'd0) begin
            n_fail++; $display("FAIL pcnt_clr_priority: got %0d want 0", pulse_total);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_burst();
        test_free_stop();
        test_div_change();
        test_start_stop();
        test_reset_midrun();
`ifdef HS_UNIT_CE_GEN_PULSE_CNT_EN
        test_pulse_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
